// File: rtl/snake_ctrl_param.sv
// Snake movement / collision engine on a parametrised cell grid.
// Holds the segment list, advances it on an internal move tick, applies
// growth requests, flags wall/self collisions and classifies the VGA pixel.
//
// Direction register (committed and pending):
//   state     | meaning
//   DIR_RIGHT | head advances +x (direction after init)
//   DIR_LEFT  | head advances -x
//   DIR_UP    | head advances -y
//   DIR_DOWN  | head advances +y
module snake_ctrl_param #(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int CELL_SHIFT = 4,
  parameter int MAX_LEN    = 16,
  parameter int INIT_LEN   = 3,
  parameter int TICK_DIV   = 12_500_000,
  parameter int WRAP_MODE  = 0
) (
  input  logic                           Clk_50mhz,
  input  logic                           Rst,
  input  logic                           Key_left,
  input  logic                           Key_right,
  input  logic                           Key_up,
  input  logic                           Key_down,
  input  logic [9:0]                     Pixel_x,
  input  logic [9:0]                     Pixel_y,
  input  logic [2:0]                     Game_status,
  input  logic                           Body_add_sig,
  input  logic                           Flash_sig,
  output logic [1:0]                     Object,
  output logic [5:0]                     Head_x,
  output logic [5:0]                     Head_y,
  output logic                           Hit_body_sig,
  output logic                           Hit_wall_sig,
  output logic [$clog2(MAX_LEN+1)-1:0]   Length,
  output logic                           Move_tick
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;

  logic [5:0]    seg_x [MAX_LEN];
  logic [5:0]    seg_y [MAX_LEN];
  dir_t          dir_c, dir_p, dir_key, dir_ref;
  logic [CW-1:0] cnt;
  logic          grow_p;
  logic [LW-1:0] len;

  logic st_start, st_play, st_end;
  logic running, terminal, grow_ok, wall_hit, body_hit;
  logic [5:0] nx, ny;
  logic [9:0] cx, cy;
  logic head_px, body_px, wall_px, show;
  logic [1:0] obj_nxt;

  assign st_start = Game_status[0];
  assign st_play  = Game_status[1];
  assign st_end   = Game_status[2];
  assign running  = st_play && !Hit_body_sig && !Hit_wall_sig;
  assign terminal = running && (cnt == CW'(TICK_DIV - 1));
  assign grow_ok  = (grow_p || Body_add_sig) && (len < LW'(MAX_LEN));
  assign Head_x   = seg_x[0];
  assign Head_y   = seg_y[0];
  assign Length   = len;

  // Key decode; reversal is judged against the direction in force after this edge.
  always_comb begin
    dir_ref = terminal ? dir_p : dir_c;
    dir_key = dir_p;
    if (Key_right && dir_ref != DIR_LEFT)  dir_key = DIR_RIGHT;
    if (Key_left  && dir_ref != DIR_RIGHT) dir_key = DIR_LEFT;
    if (Key_down  && dir_ref != DIR_UP)    dir_key = DIR_DOWN;
    if (Key_up    && dir_ref != DIR_DOWN)  dir_key = DIR_UP;
  end

  // Candidate head cell and collision classification for the next move.
  always_comb begin
    nx = seg_x[0];
    ny = seg_y[0];
    case (dir_p)
      DIR_RIGHT: nx = (seg_x[0] == 6'(GRID_W - 1)) ? 6'd0 : seg_x[0] + 6'd1;
      DIR_LEFT:  nx = (seg_x[0] == 6'd0) ? 6'(GRID_W - 1) : seg_x[0] - 6'd1;
      DIR_UP:    ny = (seg_y[0] == 6'd0) ? 6'(GRID_H - 1) : seg_y[0] - 6'd1;
      default:   ny = (seg_y[0] == 6'(GRID_H - 1)) ? 6'd0 : seg_y[0] + 6'd1;
    endcase
    wall_hit = (WRAP_MODE == 0) &&
               (nx == 6'd0 || nx == 6'(GRID_W - 1) || ny == 6'd0 || ny == 6'(GRID_H - 1));
    body_hit = 1'b0;
    // The tail vacates its cell this move unless the snake is growing.
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LW'(i) < len && (LW'(i) != len - LW'(1) || grow_ok) &&
          seg_x[i] == nx && seg_y[i] == ny)
        body_hit = 1'b1;
    end
  end

  // Pixel classification; head/body blank in END while flash is low.
  always_comb begin
    cx = Pixel_x >> CELL_SHIFT;
    cy = Pixel_y >> CELL_SHIFT;
    head_px = (cx == {4'b0, seg_x[0]}) && (cy == {4'b0, seg_y[0]});
    body_px = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LW'(i) < len && cx == {4'b0, seg_x[i]} && cy == {4'b0, seg_y[i]})
        body_px = 1'b1;
    end
    wall_px = (WRAP_MODE == 0) &&
              (cx == 10'd0 || cx == 10'(GRID_W - 1) || cy == 10'd0 || cy == 10'(GRID_H - 1));
    show = !(st_end && !Flash_sig);
    if (head_px && show)      obj_nxt = 2'b01;
    else if (body_px && show) obj_nxt = 2'b10;
    else if (wall_px)         obj_nxt = 2'b11;
    else                      obj_nxt = 2'b00;
  end

  // Registered pixel class, one cycle behind the scan coordinate.
  always_ff @(posedge Clk_50mhz) begin
    if (Rst) Object <= 2'b00;
    else     Object <= obj_nxt;
  end

  // Game state: init on reset/START, otherwise tick counter, moves, growth and hits.
  always_ff @(posedge Clk_50mhz) begin
    if (Rst || st_start) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 6'((GRID_W / 2) - i);
        seg_y[i] <= 6'(GRID_H / 2);
      end
      dir_c        <= DIR_RIGHT;
      dir_p        <= DIR_RIGHT;
      cnt          <= '0;
      grow_p       <= 1'b0;
      len          <= LW'(INIT_LEN);
      Hit_body_sig <= 1'b0;
      Hit_wall_sig <= 1'b0;
      Move_tick    <= 1'b0;
    end else begin
      Move_tick <= terminal;
      dir_p     <= dir_key;
      if (running) cnt <= terminal ? '0 : cnt + CW'(1);
      if (terminal && !wall_hit && !body_hit) grow_p <= 1'b0;
      else if (Body_add_sig)                  grow_p <= 1'b1;
      if (terminal) begin
        dir_c <= dir_p;
        if (wall_hit) begin
          Hit_wall_sig <= 1'b1;
        end else if (body_hit) begin
          Hit_body_sig <= 1'b1;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          if (grow_ok) len <= len + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_ctrl_param.sv
// Directed bench for snake_ctrl_param: a walled 4-segment instance (a) and a
// wrapping 16-segment instance (b) share stimulus, each with a 4-clock move tick.
module tb_snake_ctrl_param;

  localparam logic [2:0] GS_START = 3'b001;
  localparam logic [2:0] GS_PLAY  = 3'b010;
  localparam logic [2:0] GS_END   = 3'b100;

  logic clk = 1'b0;
  logic rst, kl, kr, ku, kd, body, flash;
  logic [9:0] px, py;
  logic [2:0] gs;

  logic [1:0] obj_a, obj_b;
  logic [5:0] hx_a, hy_a, hx_b, hy_b;
  logic hb_a, hw_a, hb_b, hw_b, mt_a, mt_b;
  logic [2:0] len_a;
  logic [4:0] len_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  snake_ctrl_param #(.MAX_LEN(4), .TICK_DIV(4), .WRAP_MODE(0)) u_a (
    .Clk_50mhz(clk), .Rst(rst), .Key_left(kl), .Key_right(kr), .Key_up(ku),
    .Key_down(kd), .Pixel_x(px), .Pixel_y(py), .Game_status(gs),
    .Body_add_sig(body), .Flash_sig(flash), .Object(obj_a), .Head_x(hx_a),
    .Head_y(hy_a), .Hit_body_sig(hb_a), .Hit_wall_sig(hw_a), .Length(len_a),
    .Move_tick(mt_a));

  snake_ctrl_param #(.MAX_LEN(16), .TICK_DIV(4), .WRAP_MODE(1)) u_b (
    .Clk_50mhz(clk), .Rst(rst), .Key_left(kl), .Key_right(kr), .Key_up(ku),
    .Key_down(kd), .Pixel_x(px), .Pixel_y(py), .Game_status(gs),
    .Body_add_sig(body), .Flash_sig(flash), .Object(obj_b), .Head_x(hx_b),
    .Head_y(hy_b), .Hit_body_sig(hb_b), .Hit_wall_sig(hw_b), .Length(len_b),
    .Move_tick(mt_b));

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic [2:0] gs;
    logic       flash;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a move pulse from instance b (which_b=1) or a, bounded.
  task automatic wait_tick(input bit which_b);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      step();
      if (which_b ? mt_b : mt_a) seen = 1'b1;
    end
    chk("move_tick_arrival", int'(seen), 1);
  endtask

  task automatic pulse_key(input int which);
    case (which)
      0: ku = 1'b1;
      1: kd = 1'b1;
      2: kl = 1'b1;
      default: kr = 1'b1;
    endcase
    step();
    {ku, kd, kl, kr} = 4'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    vecs[0]  = '{10'd320, 10'd240, GS_START, 1'b0, 2'b01, 2'b01};
    vecs[1]  = '{10'd335, 10'd255, GS_START, 1'b0, 2'b01, 2'b01};
    vecs[2]  = '{10'd336, 10'd240, GS_START, 1'b0, 2'b00, 2'b00};
    vecs[3]  = '{10'd319, 10'd240, GS_START, 1'b0, 2'b10, 2'b10};
    vecs[4]  = '{10'd288, 10'd255, GS_START, 1'b0, 2'b10, 2'b10};
    vecs[5]  = '{10'd272, 10'd240, GS_START, 1'b0, 2'b00, 2'b00};
    vecs[6]  = '{10'd0,   10'd0,   GS_START, 1'b0, 2'b11, 2'b00};
    vecs[7]  = '{10'd639, 10'd479, GS_START, 1'b0, 2'b11, 2'b00};
    vecs[8]  = '{10'd16,  10'd16,  GS_START, 1'b0, 2'b00, 2'b00};
    vecs[9]  = '{10'd320, 10'd240, GS_END,   1'b0, 2'b00, 2'b00};
    vecs[10] = '{10'd320, 10'd240, GS_END,   1'b1, 2'b01, 2'b01};
    vecs[11] = '{10'd0,   10'd0,   GS_END,   1'b0, 2'b11, 2'b00};
    vecs[12] = '{10'd304, 10'd464, GS_END,   1'b0, 2'b11, 2'b00};

    rst = 1'b1; gs = GS_START; {kl, kr, ku, kd} = 4'b0;
    body = 1'b0; flash = 1'b0; px = 10'd0; py = 10'd0;
    step(); step();
    chk("reset_object", int'(obj_a), 0);
    chk("reset_head_x", int'(hx_a), 20);
    chk("reset_head_y", int'(hy_a), 15);
    chk("reset_hits", int'({hb_a, hw_a}), 0);
    chk("reset_length", int'(len_a), 3);
    chk("reset_move_tick", int'(mt_a), 0);
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      px = vecs[v].px; py = vecs[v].py; gs = vecs[v].gs; flash = vecs[v].flash;
      step();
      chk($sformatf("object_a_vec%0d", v), int'(obj_a), int'(vecs[v].exp_a));
      chk($sformatf("object_b_vec%0d", v), int'(obj_b), int'(vecs[v].exp_b));
    end

    gs = GS_START; step();
    gs = GS_PLAY;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("tick_a_cyc%0d", k), int'(mt_a), (k % 4 == 0) ? 1 : 0);
      chk($sformatf("tick_b_cyc%0d", k), int'(mt_b), (k % 4 == 0) ? 1 : 0);
      if (k == 4) chk("head_x_first_move", int'(hx_a), 21);
      if (k == 8) begin
        chk("head_x_second_move", int'(hx_a), 22);
        chk("head_y_straight", int'(hy_a), 15);
        chk("length_straight", int'(len_a), 3);
      end
    end

    pulse_key(0);
    wait_tick(0);
    chk("up_head_y", int'(hy_a), 14);
    chk("up_head_x", int'(hx_a), 22);
    kd = 1'b1;
    wait_tick(0);
    kd = 1'b0;
    chk("reversal_ignored_y", int'(hy_a), 13);
    chk("reversal_ignored_x", int'(hx_a), 22);

    body = 1'b1; step(); body = 1'b0; step(); body = 1'b1; step(); body = 1'b0;
    wait_tick(0);
    chk("grow_once_a", int'(len_a), 4);
    chk("grow_once_b", int'(len_b), 4);
    chk("grow_head_y", int'(hy_a), 12);
    step(); step(); step();
    body = 1'b1;
    wait_tick(0);
    body = 1'b0;
    chk("grow_capped_a", int'(len_a), 4);
    chk("grow_terminal_b", int'(len_b), 5);
    chk("grow2_head_y", int'(hy_b), 11);

    pulse_key(2);
    wait_tick(1);
    chk("left_head_x_b", int'(hx_b), 21);
    chk("left_head_y_b", int'(hy_b), 11);
    pulse_key(1);
    wait_tick(1);
    chk("down_head_y_b", int'(hy_b), 12);
    chk("down_head_y_a", int'(hy_a), 12);
    pulse_key(3);
    wait_tick(1);
    chk("self_hit_b", int'(hb_b), 1);
    chk("self_hit_no_wall_b", int'(hw_b), 0);
    chk("self_hit_head_x_b", int'(hx_b), 21);
    chk("self_hit_head_y_b", int'(hy_b), 12);
    chk("tail_excluded_hit_a", int'(hb_a), 0);
    chk("tail_excluded_head_x_a", int'(hx_a), 22);
    nt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (mt_b) nt++;
    end
    chk("frozen_ticks_b", nt, 0);
    chk("frozen_head_x_b", int'(hx_b), 21);

    gs = GS_START; step();
    chk("start_head_x_a", int'(hx_a), 20);
    chk("start_head_y_a", int'(hy_a), 15);
    chk("start_hits_b", int'({hb_b, hw_b}), 0);
    chk("start_length_b", int'(len_b), 3);
    gs = GS_PLAY;
    for (int m = 1; m <= 20; m++) begin
      wait_tick(1);
      chk($sformatf("wrap_head_x_b_m%0d", m), int'(hx_b), (20 + m) % 40);
      chk($sformatf("wrap_no_hit_b_m%0d", m), int'(hw_b), 0);
      chk($sformatf("wall_tick_a_m%0d", m), int'(mt_a), (m <= 19) ? 1 : 0);
      chk($sformatf("wall_head_x_a_m%0d", m), int'(hx_a), (m < 19) ? 20 + m : 38);
      chk($sformatf("wall_flag_a_m%0d", m), int'(hw_a), (m >= 19) ? 1 : 0);
    end
    chk("wall_no_body_a", int'(hb_a), 0);

    gs = GS_START; step();
    chk("start_clears_wall_a", int'(hw_a), 0);
    chk("start_restores_x_a", int'(hx_a), 20);

    gs = GS_PLAY;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_move_head_x", int'(hx_a), 20);
    chk("rst_mid_move_tick", int'(mt_a), 0);
    step(); step(); step();
    gs = GS_START;
    step();
    chk("start_mid_move_head_x", int'(hx_a), 20);
    chk("start_mid_move_tick", int'(mt_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
